// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position tracker.
// Screen limits match the rectangle controller's 800x600 visible area.
package mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        UPDATE
    } mouse_state_t;

    localparam int LEFT_BIT  = 0;
    localparam int RIGHT_BIT = 1;
    localparam int SYNC_BIT  = 3;
    localparam int XSIGN_BIT = 4;
    localparam int YSIGN_BIT = 5;
    localparam int XOVF_BIT  = 6;
    localparam int YOVF_BIT  = 7;

    localparam int DEF_MAX_X = 799;
    localparam int DEF_MAX_Y = 599;

    localparam int POS_W = 12;
    localparam int ACC_W = 14;
    localparam int DLT_W = 9;

    // Header byte fields that matter once the packet is complete.
    typedef struct packed {
        logic yovf;
        logic xovf;
        logic ysign;
        logic xsign;
        logic right;
        logic left;
    } mouse_hdr_t;

endpackage

// File: rtl/mouse_axis_accum.sv
// One axis of the position integrator: adds (or subtracts) a 9-bit signed
// delta and clamps the result to [0, MAX] before storing it.
module mouse_axis_accum
    import mouse_pkg::*;
#(
    parameter int MAX = DEF_MAX_X
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DLT_W-1:0] delta,
    input  logic             negate,
    input  logic             ovf,
    input  logic             load,
    output logic [POS_W-1:0] pos
);

    localparam logic [POS_W-1:0]        HOME  = POS_W'((MAX + 1) / 2);
    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX);

    logic signed [ACC_W-1:0] cur;
    logic signed [ACC_W-1:0] d_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] clamped;

    // 14 bits hold 0..MAX plus or minus 256 without wrapping, so the clamp
    // sees the true result.
    always_comb begin
        cur     = $signed({{(ACC_W-POS_W){1'b0}}, pos});
        d_ext   = ovf ? '0 : $signed({{(ACC_W-DLT_W){delta[DLT_W-1]}}, delta});
        sum     = negate ? (cur - d_ext) : (cur + d_ext);
        clamped = sum;
        if (sum < 0) begin
            clamped = '0;
        end else if (sum > MAX_S) begin
            clamped = MAX_S;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= HOME;
        end else if (load) begin
            pos <= clamped[POS_W-1:0];
        end
    end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 mouse packets with sync and inter-byte timeout, and
// drives absolute clamped X/Y coordinates plus button levels.
module mouse_pos_tracker
    import mouse_pkg::*;
#(
    parameter int MAX_X          = DEF_MAX_X,
    parameter int MAX_Y          = DEF_MAX_Y,
    parameter int TIMEOUT_CYCLES = 80000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [POS_W-1:0] mouse_x_position,
    output logic [POS_W-1:0] mouse_y_position,
    output logic             mouse_left,
    output logic             mouse_right,
    output logic             packet_valid
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mouse_state_t     state_q, state_d;
    mouse_hdr_t       hdr_q;
    logic [7:0]       dx_lo_q, dy_lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mid_packet, timeout_hit;
    logic             take_b0, take_b1, take_b2;

    assign mid_packet  = (state_q == WAIT_B1) || (state_q == WAIT_B2);
    assign timeout_hit = mid_packet && (cnt_q == CNT_LIMIT);

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        take_b0 = 1'b0;
        take_b1 = 1'b0;
        take_b2 = 1'b0;
        unique case (state_q)
            WAIT_B0: begin
                if (rx_valid && rx_data[SYNC_BIT]) begin
                    take_b0 = 1'b1;
                    state_d = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (timeout_hit) begin
                    state_d = WAIT_B0;
                end else if (rx_valid) begin
                    take_b1 = 1'b1;
                    state_d = WAIT_B2;
                end
            end
            WAIT_B2: begin
                if (timeout_hit) begin
                    state_d = WAIT_B0;
                end else if (rx_valid) begin
                    take_b2 = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: state_d = WAIT_B0;
            default: state_d = WAIT_B0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_B0;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q   <= '0;
            dx_lo_q <= '0;
            dy_lo_q <= '0;
        end else begin
            if (take_b0) begin
                hdr_q <= '{yovf:  rx_data[YOVF_BIT],
                           xovf:  rx_data[XOVF_BIT],
                           ysign: rx_data[YSIGN_BIT],
                           xsign: rx_data[XSIGN_BIT],
                           right: rx_data[RIGHT_BIT],
                           left:  rx_data[LEFT_BIT]};
            end
            if (take_b1) dx_lo_q <= rx_data;
            if (take_b2) dy_lo_q <= rx_data;
        end
    end

    // Counts idle cycles only while a packet is partially assembled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (mid_packet && !take_b1 && !take_b2 && !timeout_hit) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mouse_left   <= 1'b0;
            mouse_right  <= 1'b0;
            packet_valid <= 1'b0;
        end else begin
            packet_valid <= (state_q == UPDATE);
            if (state_q == UPDATE) begin
                mouse_left  <= hdr_q.left;
                mouse_right <= hdr_q.right;
            end
        end
    end

    mouse_axis_accum #(.MAX(MAX_X)) u_x_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .delta  ({hdr_q.xsign, dx_lo_q}),
        .negate (1'b0),
        .ovf    (hdr_q.xovf),
        .load   (state_q == UPDATE),
        .pos    (mouse_x_position)
    );

    // PS/2 reports up as positive; the screen grows downward.
    mouse_axis_accum #(.MAX(MAX_Y)) u_y_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .delta  ({hdr_q.ysign, dy_lo_q}),
        .negate (1'b1),
        .ovf    (hdr_q.yovf),
        .load   (state_q == UPDATE),
        .pos    (mouse_y_position)
    );

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed bench for mouse_pos_tracker: a driver queues hand-computed
// expectations, a monitor pops them on each packet_valid pulse.
module tb_mouse_pos_tracker;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [11:0] mouse_x_position, mouse_y_position;
    logic        mouse_left, mouse_right, packet_valid;

    typedef struct {
        int x;
        int y;
        int l;
        int r;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_edge = 0;

    mouse_pos_tracker #(
        .MAX_X          (799),
        .MAX_Y          (599),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .mouse_x_position (mouse_x_position),
        .mouse_y_position (mouse_y_position),
        .mouse_left       (mouse_left),
        .mouse_right      (mouse_right),
        .packet_valid     (packet_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs(input string tag, input int ex, input int ey,
                                 input int el, input int er);
        check({tag, "_x"}, int'(mouse_x_position), ex);
        check({tag, "_y"}, int'(mouse_y_position), ey);
        check({tag, "_left"}, int'(mouse_left), el);
        check({tag, "_right"}, int'(mouse_right), er);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        last_edge = cyc;
        rx_valid  = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int ex, input int ey,
                               input int el, input int er);
        exp_t e;
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        e = '{x: ex, y: ey, l: el, r: er, cyc: last_edge + 1};
        sb.push_back(e);
        idle(3);
    endtask

    always @(negedge clk) begin
        if (rst_n && packet_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_packet_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pkt_x", int'(mouse_x_position), e.x);
                check("pkt_y", int'(mouse_y_position), e.y);
                check("pkt_left", int'(mouse_left), e.l);
                check("pkt_right", int'(mouse_right), e.r);
                check("pkt_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        #1 rst_n = 1'b1;
        idle(5);
        @(negedge clk);
        check_outputs("reset", 400, 300, 0, 0);
        check("reset_pv", int'(packet_valid), 0);

        send_packet(8'h09, 8'h0A, 8'h05, 410, 295, 1, 0);

        // Back to centre, then drive X into the right edge and back to 0.
        @(posedge clk); #1 rst_n = 1'b0;
        idle(2); #1 rst_n = 1'b1;
        send_packet(8'h08, 8'hFF, 8'h00, 655, 300, 0, 0);
        send_packet(8'h08, 8'hFF, 8'h00, 799, 300, 0, 0);
        send_packet(8'h18, 8'h00, 8'h00, 543, 300, 0, 0);
        send_packet(8'h18, 8'h00, 8'h00, 287, 300, 0, 0);
        send_packet(8'h18, 8'h00, 8'h00,  31, 300, 0, 0);
        send_packet(8'h18, 8'h00, 8'h00,   0, 300, 0, 0);

        // Y: dy=-256 moves down to the bottom clamp, dy=+255 back to 0.
        send_packet(8'h28, 8'h00, 8'h00, 0, 556, 0, 0);
        send_packet(8'h28, 8'h00, 8'h00, 0, 599, 0, 0);
        send_packet(8'h08, 8'h00, 8'hFF, 0, 344, 0, 0);
        send_packet(8'h08, 8'h00, 8'hFF, 0,  89, 0, 0);
        send_packet(8'h08, 8'h00, 8'hFF, 0,   0, 0, 0);

        // Stray byte without sync bit is dropped.
        send_byte(8'h00);
        send_packet(8'h08, 8'h00, 8'h00, 0, 0, 0, 0);

        // Partial packet abandoned by timeout, then a fresh packet.
        send_byte(8'h08);
        send_byte(8'h10);
        idle(TMO + 10);
        @(negedge clk);
        check_outputs("after_timeout", 0, 0, 0, 0);
        send_packet(8'h0A, 8'h00, 8'h00, 0, 0, 0, 1);

        // Gap just under the timeout keeps the packet alive.
        send_byte(8'h08);
        send_byte(8'h05);
        idle(TMO - 20);
        send_byte(8'h00);
        sb.push_back('{x: 5, y: 0, l: 0, r: 0, cyc: last_edge + 1});
        idle(3);

        // Overflow flags zero the affected delta only.
        send_packet(8'h28, 8'h00, 8'h00, 5, 256, 0, 0);
        send_packet(8'h58, 8'h7F, 8'h01, 5, 255, 0, 0);
        send_packet(8'h89, 8'h03, 8'h50, 8, 255, 1, 0);

        // Reset mid-packet: outputs snap back, partial packet is gone.
        send_byte(8'h08);
        send_byte(8'h05);
        #1 rst_n = 1'b0;
        #1;
        check_outputs("mid_reset", 400, 300, 0, 0);
        idle(2);
        #1 rst_n = 1'b1;
        send_packet(8'h08, 8'h01, 8'h00, 401, 300, 0, 0);

        idle(10);
        @(negedge clk);
        check_outputs("hold", 401, 300, 0, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mouse_pos_tracker.md
# mouse_pos_tracker

Converts the byte stream of the PS/2 receiver into absolute, clamped screen coordinates and button levels. Assembles standard 3-byte PS/2 mouse packets, enforces packet sync and an inter-byte timeout, and integrates signed deltas into X/Y positions. Sits directly upstream of the rectangle controller, driving its `mouse_x_position`, `mouse_y_position` and `mouse_left` inputs.

## Interface
- `MAX_X`, 799: largest X coordinate; X clamped to [0, MAX_X].
- `MAX_Y`, 599: largest Y coordinate; Y clamped to [0, MAX_Y].
- `TIMEOUT_CYCLES`, 80000: idle cycles between bytes of one packet before resync (2 ms at 40 MHz).
- `clk` in 1: system clock, single domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx_data` in 8: byte from PS/2 receiver.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `mouse_x_position` out 12: absolute X, registered.
- `mouse_y_position` out 12: absolute Y, registered, screen-down positive.
- `mouse_left` out 1: left button level.
- `mouse_right` out 1: right button level.
- `packet_valid` out 1: one-cycle pulse when outputs update.

## Operation
- FSM states: `WAIT_B0`, `WAIT_B1`, `WAIT_B2`, `UPDATE`.
- `WAIT_B0`: on `rx_valid`, accept only if `rx_data[3]==1`; latch byte 0, go `WAIT_B1`. Bit3=0: drop byte, stay.
- `WAIT_B1`: on `rx_valid`, latch dx low byte, go `WAIT_B2`.
- `WAIT_B2`: on `rx_valid`, latch dy low byte, go `UPDATE`.
- `UPDATE`: one cycle; apply packet, pulse `packet_valid`, return to `WAIT_B0`. `rx_valid` during `UPDATE` is ignored (PS/2 byte rate makes it impossible in practice; no buffering).
- Deltas: dx = {b0[4], b1} and dy = {b0[5], b2}, 9-bit two's complement (range -256..255).
- Overflow: b0[6] set -> dx treated as 0; b0[7] set -> dy treated as 0; buttons still update.
- X: new = clamp(x + dx, 0, MAX_X).
- Y inverted: new = clamp(y - dy, 0, MAX_Y) (PS/2 up positive, screen down positive).
- Arithmetic in 14-bit signed; clamp before truncating to 12 bits.
- Buttons: `mouse_left` = b0[0], `mouse_right` = b0[1], updated only in `UPDATE`.
- Timeout counter: cleared on every accepted byte; counts while in `WAIT_B1`/`WAIT_B2`; on reaching `TIMEOUT_CYCLES` -> `WAIT_B0`, partial packet discarded, outputs unchanged. Idle in `WAIT_B0`/`UPDATE`.
- `rx_valid` arriving the same cycle the counter expires: timeout wins; byte re-evaluated as byte 0 is not required (byte dropped).

## Timing
- Reset (asynchronous, `rst_n`=0): state `WAIT_B0`, X = (MAX_X+1)/2 = 400, Y = (MAX_Y+1)/2 = 300, buttons 0, `packet_valid` 0, timeout counter 0.
- Reset mid-packet: partial packet discarded, outputs return to reset values immediately.
- Latency: third byte strobe at cycle N -> `UPDATE` at N+1 -> new positions/buttons and `packet_valid` visible at N+2.
- Outputs hold between packets; no glitches outside the `UPDATE` edge.

## Structure
- Package `mouse_pkg`: state enum `mouse_state_t`, packet bit indices (SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7), default screen limits shared with the rectangle controller (800x600 visible).
- Sub-module `mouse_axis_accum` (parameter MAX, inputs delta, negate, ovf, load strobe; registered clamped 12-bit position), instantiated for X (negate=0) and Y (negate=1).
- Top holds FSM, byte latches, timeout counter, button registers.

## Test plan
- Reset release, no traffic -> X=400, Y=300, buttons 0, no `packet_valid`.
- Packet 0x09, 0x0A, 0x05 -> X=410, Y=295, left=1, `packet_valid` 2 cycles after third strobe.
- From X=400: packets with dx=+255 repeated 2 -> X=799 clamped; dx=-256 (b0=0x18, b1=0x00) x4 from 799 -> X=0.
- Stray byte 0x00 then 0x08, 0x00, 0x00 -> first byte dropped, one packet accepted, positions unchanged, buttons 0.
- Bytes 0x08, 0x10 then gap of TIMEOUT_CYCLES -> resync; following 0x0A, 0x00, 0x00 parsed as fresh packet, right=1.
- Byte 0 = 0x58 (X overflow), dx=0x7F, dy=0x01 -> X unchanged, Y decremented by 1.
